dfu_boot_sequencer: RTL and testbench
=====================================

# dfu_boot_sequencer

Boot-control stage directly downstream of `usb_dfu_core` in the TinyDFU bootloader top level. It consumes the core's `dfu_state` and `dfu_detach` and produces four things:
- the core's power-on reset;
- the USB host-detect pull-up enable;
- the user-image boot request that drives the FPGA `resetn` pin;
- the status LED patterns.

It replaces the ad-hoc counters in each board top with one verified sequencer.

## Interface
Parameters:
- `RESET_CYCLES`, 65535: `clk` cycles `core_reset` is held after `reset` deasserts.
- `BOOT_DELAY`, 60000000: auto-boot timeout in `clk` cycles (5 s at 12 MHz).
- `HOLDOFF_CYCLES`, 12000: delay from boot decision to `user_boot` (1 ms at 12 MHz). Lets the final USB status stage complete.
- `BLINK_BIT`, 21: counter bit used for the idle blink.
- `STEP_BIT`, 20: counter bit whose rising transition advances the cylon pattern.

Ports:
- `clk` in 1: system clock (12 MHz). Single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dfu_state` in 8: DFU state from `usb_dfu_core`, synchronous to `clk`.
- `dfu_detach` in 1: detach pulse from `usb_dfu_core`, synchronous to `clk`.
- `core_reset` out 1: active-high reset to `usb_dfu_core`.
- `usb_pull_en` out 1: 1 enables the D+ pull-up (top inverts it into BB `.T`).
- `user_boot` out 1: 1 drives `resetn` low (top feeds `~user_boot` into BB `.T`).
- `led` out 3: active-low LEDs.
- `seq_state` out 3: current FSM state encoding, for debug.

## Operation
FSM states, in encoding order 0–4:

- **POR (0)**
  - `core_reset`=1, `usb_pull_en`=0.
  - Down-counter loads `RESET_CYCLES` on reset and decrements each cycle.
  - Transition: counter==0 → WAIT.
- **WAIT (1)**
  - `core_reset`=0, `usb_pull_en`=1.
  - Boot counter loads `BOOT_DELAY` on entry and decrements.
  - Transition, priority order:
    - `dfu_detach`=1 → HOLDOFF.
    - else `dfu_state`>2 → ACTIVE.
    - else boot counter==0 → HOLDOFF.
- **ACTIVE (2)**
  - Auto-boot is cancelled permanently until `reset`.
  - Only exit: `dfu_detach`=1 → HOLDOFF.
  - A later return of `dfu_state` to ≤2 does not re-arm auto-boot.
- **HOLDOFF (3)**
  - Counter loads `HOLDOFF_CYCLES` on entry.
  - Transition: counter==0 → BOOT.
  - `dfu_detach` and `dfu_state` are ignored.
- **BOOT (4)**
  - `user_boot`=1, sticky; exit only via `reset`.
  - `usb_pull_en` stays 1 and `core_reset` stays 0.

LED behaviour:
- A free-running 32-bit counter `led_counter` (wraps) generates the pattern.
- Pattern selection:
  - `dfu_state`==8'h02 in WAIT/ACTIVE: `led` = ~{2'b00, `led_counter[BLINK_BIT]`}.
  - Other `dfu_state` in WAIT/ACTIVE: cylon. A 2-bit step index advances on each 0→1 transition of `led_counter[STEP_BIT]`, detected with a registered previous bit. No derived clocks.
  - Cylon pattern by step 0,1,2,3 = 001, 010, 100, 010, then wraps to step 0; `led` = ~pattern.
  - POR, HOLDOFF and BOOT: `led` = 3'b111 (all off).
- The cylon step index resets to 0 and keeps free-running whether or not it is displayed.

Width rules:
- Each counter is sized by `$clog2` of its parameter plus 1.
- Counters saturate at 0; there is no wrap.
- A parameter value of 0 means immediate transition on the next cycle.

## Timing
- Reset values (async, immediate): state=POR; `core_reset`=1; `usb_pull_en`=0; `user_boot`=0; `led`=3'b111; `seq_state`=0; all counters at their load values or 0.
- All outputs are registered and change on the clock edge after the state change.
- Reset-to-WAIT timing:
  - `core_reset` falls and `usb_pull_en` rises RESET_CYCLES+1 edges after `reset` deasserts.
  - Both change on the same edge.
- `dfu_detach` sampled in WAIT/ACTIVE:
  - HOLDOFF is entered on the next edge.
  - `user_boot` rises HOLDOFF_CYCLES+2 edges after the sampled pulse.
- Simultaneous events in WAIT:
  - detach and timeout together: detach wins. The result is identical (HOLDOFF).
  - `dfu_state`>2 in the same cycle the boot counter reaches 0: ACTIVE wins. Auto-boot is cancelled.
- `reset` asserted in any state, including BOOT: immediate return to reset values; `user_boot` drops asynchronously.
- One-cycle `dfu_detach` pulses must be captured; no pulse-width requirement.

## Test plan
Run with RESET_CYCLES=4, BOOT_DELAY=20, HOLDOFF_CYCLES=3, BLINK_BIT=2, STEP_BIT=1.

1. **Power-on:** release `reset` at edge 0 → `core_reset`=1 and `usb_pull_en`=0 through edge 4; both flip at edge 5; `led`=111 until then.
2. **Auto-boot:** `dfu_state`=2 held, no detach → `user_boot` rises HOLDOFF+2 edges after the boot counter hits 0 and stays 1 for 100 cycles. During WAIT, `led[0]` toggles every 4 cycles and `led[2:1]`=11.
3. **Cancel:** `dfu_state`=5 at WAIT cycle 10, back to 2 at cycle 30 → `seq_state`=2 and `user_boot`=0 for 200 cycles; `led` cycles 110, 101, 011, 101, advancing every 4 cycles.
4. **Detach:** in ACTIVE, one-cycle `dfu_detach` → `seq_state`=3 next edge; `user_boot`=1 5 edges after the pulse.
5. **Race:** `dfu_state`=3 on the exact cycle the boot counter reaches 0 → ACTIVE, no boot. Separately, detach on the timeout cycle → HOLDOFF.
6. **Reset mid-operation:** assert `reset` in HOLDOFF and again in BOOT → outputs return to reset values without a clock edge; the full POR sequence repeats after release.

Source files
------------

// File: rtl/dfu_boot_sequencer_if.sv
// -----------------------------------------------------------------------------
// dfu_boot_sequencer_if
//
// Purpose:
//   Bundles the signals exchanged between usb_dfu_core / the board top and the
//   boot sequencer into one interface.
//
// Signals:
//   dfu_state   [7:0]  DFU state reported by usb_dfu_core (sync to clk)
//   dfu_detach         one-cycle detach pulse from usb_dfu_core (sync to clk)
//   core_reset         active-high reset to usb_dfu_core
//   usb_pull_en        1 enables the D+ pull-up
//   user_boot          1 requests the user image (drives resetn low)
//   led         [2:0]  active-low status LEDs
//   seq_state   [2:0]  sequencer state encoding, for debug
//
// Modports:
//   master  core/board-top side: drives the DFU status, receives controls
//   slave   sequencer side: receives the DFU status, drives controls
// -----------------------------------------------------------------------------
interface dfu_boot_sequencer_if;
   logic [7:0] dfu_state;
   logic       dfu_detach;
   logic       core_reset;
   logic       usb_pull_en;
   logic       user_boot;
   logic [2:0] led;
   logic [2:0] seq_state;

   modport master (
      output dfu_state,
      output dfu_detach,
      input  core_reset,
      input  usb_pull_en,
      input  user_boot,
      input  led,
      input  seq_state
   );

   modport slave (
      input  dfu_state,
      input  dfu_detach,
      output core_reset,
      output usb_pull_en,
      output user_boot,
      output led,
      output seq_state
   );
endinterface

// File: rtl/dfu_boot_sequencer.sv
// -----------------------------------------------------------------------------
// dfu_boot_sequencer
//
// Purpose:
//   Boot-control stage downstream of usb_dfu_core. Holds the core in reset
//   after power-on, then enables the USB pull-up and waits for either DFU
//   activity, a detach request or an auto-boot timeout. A boot decision is
//   followed by a short holdoff before the sticky user_boot request. Also
//   drives the status LED patterns (idle blink / cylon).
//
// Ports:
//   clk    in   system clock, all logic on its rising edge
//   reset  in   asynchronous active-high reset
//   bus    slave modport of dfu_boot_sequencer_if
//            in : dfu_state[7:0], dfu_detach
//            out: core_reset, usb_pull_en, user_boot, led[2:0], seq_state[2:0]
// -----------------------------------------------------------------------------
module dfu_boot_sequencer #(
   parameter int unsigned RESET_CYCLES   = 65535,
   parameter int unsigned BOOT_DELAY     = 60000000,
   parameter int unsigned HOLDOFF_CYCLES = 12000,
   parameter int unsigned BLINK_BIT      = 21,
   parameter int unsigned STEP_BIT       = 20
) (
   input logic                 clk,
   input logic                 reset,
   dfu_boot_sequencer_if.slave bus
);

   localparam int POR_W  = $clog2(RESET_CYCLES) + 1;
   localparam int BOOT_W = $clog2(BOOT_DELAY) + 1;
   localparam int HOLD_W = $clog2(HOLDOFF_CYCLES) + 1;

   typedef enum logic [2:0] {
      ST_POR     = 3'd0,
      ST_WAIT    = 3'd1,
      ST_ACTIVE  = 3'd2,
      ST_HOLDOFF = 3'd3,
      ST_BOOT    = 3'd4
   } seq_state_t;

   seq_state_t        state;
   seq_state_t        next_state;
   logic [POR_W-1:0]  por_cnt;
   logic [BOOT_W-1:0] boot_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [31:0]       led_counter;
   logic [31:0]       led_counter_next;
   logic              step_prev;
   logic              step_rise;
   logic [1:0]        step_idx;
   logic [1:0]        step_next;
   logic [2:0]        led_next;

   // State register; ACTIVE has no timeout path, so once entered the
   // auto-boot stays cancelled until the next reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_POR;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. In WAIT the detach request beats DFU activity, which
   // in turn beats the timeout, so activity arriving on the timeout cycle
   // still cancels auto-boot.
   always_comb begin
      next_state = state;
      case (state)
         ST_POR: begin
            if (por_cnt == '0) next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.dfu_detach)              next_state = ST_HOLDOFF;
            else if (bus.dfu_state > 8'd2)   next_state = ST_ACTIVE;
            else if (boot_cnt == '0)         next_state = ST_HOLDOFF;
         end
         ST_ACTIVE: begin
            if (bus.dfu_detach) next_state = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (hold_cnt == '0) next_state = ST_BOOT;
         end
         ST_BOOT: begin
            next_state = ST_BOOT;
         end
         default: begin
            next_state = ST_POR;
         end
      endcase
   end

   // Phase counters. Each one loads when its state is entered (the POR counter
   // only via reset) and counts down to 0 where it saturates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         por_cnt  <= POR_W'(RESET_CYCLES);
         boot_cnt <= BOOT_W'(BOOT_DELAY);
         hold_cnt <= HOLD_W'(HOLDOFF_CYCLES);
      end else begin
         if (state == ST_POR && por_cnt != '0) begin
            por_cnt <= por_cnt - POR_W'(1);
         end

         if (state != ST_WAIT && next_state == ST_WAIT) begin
            boot_cnt <= BOOT_W'(BOOT_DELAY);
         end else if (state == ST_WAIT && boot_cnt != '0) begin
            boot_cnt <= boot_cnt - BOOT_W'(1);
         end

         if (state != ST_HOLDOFF && next_state == ST_HOLDOFF) begin
            hold_cnt <= HOLD_W'(HOLDOFF_CYCLES);
         end else if (state == ST_HOLDOFF && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
         end
      end
   end

   // LED pattern generation. The cylon step advances on a rising transition
   // of one counter bit, detected against a registered copy of that bit so no
   // derived clock is needed. The step keeps running even when not shown.
   always_comb begin
      led_counter_next = led_counter + 32'd1;
      step_rise        = led_counter[STEP_BIT] & ~step_prev;
      step_next        = step_idx + {1'b0, step_rise};
      led_next         = 3'b111;
      if (next_state == ST_WAIT || next_state == ST_ACTIVE) begin
         if (bus.dfu_state == 8'h02) begin
            led_next = ~{2'b00, led_counter_next[BLINK_BIT]};
         end else begin
            case (step_next)
               2'd0:    led_next = ~3'b001;
               2'd1:    led_next = ~3'b010;
               2'd2:    led_next = ~3'b100;
               default: led_next = ~3'b010;
            endcase
         end
      end
   end

   // Output registers, loaded from the next state so every output changes on
   // the same edge as the state it belongs to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_counter     <= '0;
         step_prev       <= 1'b0;
         step_idx        <= 2'd0;
         bus.led         <= 3'b111;
         bus.core_reset  <= 1'b1;
         bus.usb_pull_en <= 1'b0;
         bus.user_boot   <= 1'b0;
         bus.seq_state   <= ST_POR;
      end else begin
         led_counter     <= led_counter_next;
         step_prev       <= led_counter[STEP_BIT];
         step_idx        <= step_next;
         bus.led         <= led_next;
         bus.core_reset  <= (next_state == ST_POR);
         bus.usb_pull_en <= (next_state != ST_POR);
         bus.user_boot   <= (next_state == ST_BOOT);
         bus.seq_state   <= next_state;
      end
   end

endmodule

// File: tb/tb_dfu_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dfu_boot_sequencer
//
// Purpose:
//   Directed bench for dfu_boot_sequencer with small parameters. A reference
//   model tracks the sequencer in terms of edge timestamps; each driven cycle
//   pushes the expected outputs onto a scoreboard queue, which is popped and
//   compared just after the clock edge.
// -----------------------------------------------------------------------------
module tb_dfu_boot_sequencer;

   localparam int RC  = 4;
   localparam int BD  = 20;
   localparam int HO  = 3;
   localparam int BLK = 2;
   localparam int STP = 1;

   typedef enum int {M_POR, M_WAIT, M_ACTIVE, M_HOLDOFF, M_BOOT} model_state_t;

   typedef struct packed {
      logic       core_reset;
      logic       usb_pull_en;
      logic       user_boot;
      logic [2:0] led;
      logic [2:0] seq_state;
   } exp_t;

   localparam exp_t RESET_EXP = '{1'b1, 1'b0, 1'b0, 3'b111, 3'd0};

   logic clk = 1'b0;
   logic reset = 1'b0;

   dfu_boot_sequencer_if bus ();

   dfu_boot_sequencer #(
      .RESET_CYCLES   (RC),
      .BOOT_DELAY     (BD),
      .HOLDOFF_CYCLES (HO),
      .BLINK_BIT      (BLK),
      .STEP_BIT       (STP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t         exp_q[$];
   int           vectors    = 0;
   int           miscompares = 0;
   int           n          = 0;
   int           t_enter    = 0;
   model_state_t mstate     = M_POR;
   string        phase      = "init";

   // Expected LED pattern after edge n in WAIT/ACTIVE. Edge n leaves the
   // free-running counter at n; the cylon step has advanced once for every
   // edge whose previous counter value had a fresh rising step bit.
   function automatic logic [2:0] model_led(input int edge_n, input logic [7:0] st);
      int step;
      if (st == 8'h02) begin
         return {2'b11, ~(((edge_n >> BLK) & 1) != 0)};
      end
      step = ((edge_n - 1 + (1 << STP)) / (1 << (STP + 1))) % 4;
      case (step)
         0:       return 3'b110;
         1:       return 3'b101;
         2:       return 3'b011;
         default: return 3'b101;
      endcase
   endfunction

   function automatic exp_t model_outputs(input model_state_t ms, input int edge_n,
                                          input logic [7:0] st);
      exp_t e;
      case (ms)
         M_POR:     e = '{1'b1, 1'b0, 1'b0, 3'b111, 3'd0};
         M_WAIT:    e = '{1'b0, 1'b1, 1'b0, model_led(edge_n, st), 3'd1};
         M_ACTIVE:  e = '{1'b0, 1'b1, 1'b0, model_led(edge_n, st), 3'd2};
         M_HOLDOFF: e = '{1'b0, 1'b1, 1'b0, 3'b111, 3'd3};
         default:   e = '{1'b0, 1'b1, 1'b1, 3'b111, 3'd4};
      endcase
      return e;
   endfunction

   // Pops the oldest expectation and compares it with the DUT outputs.
   task automatic check_output();
      exp_t exp_v;
      exp_t obs;
      exp_v = exp_q.pop_front();
      obs   = {bus.core_reset, bus.usb_pull_en, bus.user_boot, bus.led, bus.seq_state};
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("[TB] FAIL %s edge %0d: observed %b required %b", phase, n, obs, exp_v);
      end
   endtask

   // Drives one cycle of inputs, advances the reference model for the coming
   // edge, queues the expectation and checks after the edge.
   task automatic apply_stimulus(input logic [7:0] st, input logic det);
      bus.dfu_state  = st;
      bus.dfu_detach = det;
      n++;
      case (mstate)
         M_POR: begin
            if (n >= RC + 1) begin
               mstate  = M_WAIT;
               t_enter = n;
            end
         end
         M_WAIT: begin
            if (det) begin
               mstate  = M_HOLDOFF;
               t_enter = n;
            end else if (st > 8'd2) begin
               mstate = M_ACTIVE;
            end else if (n >= t_enter + BD + 1) begin
               mstate  = M_HOLDOFF;
               t_enter = n;
            end
         end
         M_ACTIVE: begin
            if (det) begin
               mstate  = M_HOLDOFF;
               t_enter = n;
            end
         end
         M_HOLDOFF: begin
            if (n >= t_enter + HO + 1) mstate = M_BOOT;
         end
         default: begin
            mstate = M_BOOT;
         end
      endcase
      exp_q.push_back(model_outputs(mstate, n, st));
      @(posedge clk);
      #1;
      check_output();
   endtask

   // Asserts reset away from any clock edge, checks the outputs fell back
   // asynchronously, then releases reset just after an edge.
   task automatic reset_check(input string tag);
      phase = tag;
      reset = 1'b1;
      #2;
      exp_q.push_back(RESET_EXP);
      check_output();
      @(posedge clk);
      #1;
      bus.dfu_state  = 8'd2;
      bus.dfu_detach = 1'b0;
      reset   = 1'b0;
      n       = 0;
      t_enter = 0;
      mstate  = M_POR;
   endtask

   initial begin
      bus.dfu_state  = 8'd2;
      bus.dfu_detach = 1'b0;
      #1;
      reset_check("por_reset");

      phase = "power_on";
      repeat (RC + 1) apply_stimulus(8'd2, 1'b0);

      phase = "auto_boot";
      repeat (BD + 1 + HO + 1 + 100) apply_stimulus(8'd2, 1'b0);

      reset_check("reset_in_boot");

      phase = "cancel";
      repeat (RC + 1) apply_stimulus(8'd2, 1'b0);
      repeat (9) apply_stimulus(8'd2, 1'b0);
      repeat (20) apply_stimulus(8'd5, 1'b0);
      repeat (200) apply_stimulus(8'd2, 1'b0);

      phase = "detach";
      apply_stimulus(8'd5, 1'b1);
      repeat (10) apply_stimulus(8'd5, 1'b0);

      reset_check("reset_after_detach");

      phase = "race_active";
      repeat (RC + 1 + BD) apply_stimulus(8'd2, 1'b0);
      apply_stimulus(8'd3, 1'b0);
      repeat (30) apply_stimulus(8'd3, 1'b0);
      repeat (10) apply_stimulus(8'd1, 1'b0);

      reset_check("reset_in_active");

      phase = "race_detach";
      repeat (RC + 1 + BD) apply_stimulus(8'd2, 1'b0);
      apply_stimulus(8'd2, 1'b1);
      apply_stimulus(8'd7, 1'b1);

      reset_check("reset_in_holdoff");

      phase = "por_repeat";
      repeat (RC + 1) apply_stimulus(8'd0, 1'b0);
      repeat (12) apply_stimulus(8'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
